// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a valid/ready byte stream feeds a small FIFO
// that drains back-to-back frames onto a registered, idle-high serial line.
module uart_tx_fifo #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [7:0]                    in_data_i,
    output logic                          txd_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned PW           = AW + 1;
    localparam int unsigned BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] DEPTH_P    = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   count_q, count_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            empty;
    logic            baud_done;
    logic [7:0]      head;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign baud_done = (baud_q == BAUD_LAST);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    // Frame sequencing, FIFO bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        push     = in_valid_i & ready_q;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next frame so the line never idles between bytes.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + PW'(push) - PW'(pop);
        ready_d  = (count_d != DEPTH_P);
        busy_d   = (state_q != IDLE) || (count_q != '0);

        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
        end
    end

    assign in_ready_o   = ready_q;
    assign txd_o        = txd_q;
    assign busy_o       = busy_q;
    assign fifo_count_o = count_q;

endmodule
